// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared encodings and test patterns for the SRAM self-test engine.
package ram_bist_pkg;

    localparam int ADDR_W = 18;

    typedef enum logic [1:0] {PH_WW, PH_WR, PH_BW, PH_BR} phase_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_GAP, S_PASS} state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_WORD = 2'd1;
    localparam logic [1:0] ERR_BYTE = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Both patterns take the word index a[16:1] / a[8:1] rather than the byte address.
    function automatic logic [15:0] pat_w(input logic [15:0] word_idx, input logic [15:0] seed);
        return word_idx ^ seed;
    endfunction

    function automatic logic [7:0] pat_b(input logic [7:0] word_idx);
        return 8'hA5 ^ word_idx;
    endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// ram_bist_addr_gen: loadable ascending word-address counter that stops at ADDR_HI.
module ram_bist_addr_gen
    import ram_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_LO = 18'h00000,
    parameter logic [ADDR_W-1:0] ADDR_HI = 18'h3FFFE
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    assign last = addr == ADDR_HI;

    always_ff @(posedge clk) begin
        if (reset || load)
            addr <= ADDR_LO;
        else if (step && !last)
            addr <= addr + ADDR_W'(2);
    end

endmodule

// File: rtl/ram_bist.sv
// ram_bist: four-phase SRAM self-test initiator on the rd/wr/done memory port.
// Stops at the first data mismatch or when mem_done fails to arrive within TIMEOUT cycles.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_LO = 18'h00000,
    parameter logic [ADDR_W-1:0] ADDR_HI = 18'h3FFFE,
    parameter logic [15:0]       SEED    = 16'h5A3C,
    parameter int                TIMEOUT = 255
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] err_addr,
    output logic [15:0]       err_exp,
    output logic [15:0]       err_got,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_wr_inhibit,
    output logic              mem_byte_op,
    input  logic              mem_done
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t            state;
    phase_t            phase;
    logic              fin;
    logic [7:0]        tmo_cnt;
    logic [ADDR_W-1:0] addr;
    logic              last;
    logic [15:0]       w_cur;
    logic [7:0]        b_cur;
    logic [15:0]       exp_word;
    logic              is_rd;
    logic              acc_done;
    logic              mismatch;
    logic              tmo_hit;

    assign mem_wr_inhibit = 1'b0;
    assign w_cur    = pat_w(addr[16:1], SEED);
    assign b_cur    = pat_b(addr[8:1]);
    assign is_rd    = (phase == PH_WR) || (phase == PH_BR);
    // Write phases record the data driven; read phases the data they expect back.
    assign exp_word = (phase == PH_BR) ? {b_cur, w_cur[7:0]} : mem_wdata;
    assign acc_done = (state == S_REQ) && mem_done;
    assign mismatch = is_rd && (mem_rdata != exp_word);
    assign tmo_hit  = (state == S_REQ) && !mem_done && (tmo_cnt == TMO_LAST);

    ram_bist_addr_gen #(.ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)) u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .load  (((state == S_IDLE) && start) || (acc_done && last)),
        .step  (acc_done),
        .addr  (addr),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            phase       <= PH_WW;
            fin         <= 1'b0;
            tmo_cnt     <= '0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            err_code    <= ERR_NONE;
            err_addr    <= '0;
            err_exp     <= '0;
            err_got     <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_byte_op <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_LOAD;
                    phase    <= PH_WW;
                    fin      <= 1'b0;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    fail     <= 1'b0;
                    err_code <= ERR_NONE;
                    err_addr <= '0;
                    err_exp  <= '0;
                    err_got  <= '0;
                end
                S_LOAD, S_GAP: begin
                    if (fin) begin
                        state <= S_PASS;
                    end else begin
                        state       <= S_REQ;
                        tmo_cnt     <= '0;
                        mem_addr    <= (phase == PH_BW) ? (addr | ADDR_W'(1)) : addr;
                        mem_wdata   <= (phase == PH_BW) ? {8'h00, b_cur} : w_cur;
                        mem_byte_op <= phase == PH_BW;
                        mem_rd      <= is_rd;
                        mem_wr      <= !is_rd;
                    end
                end
                S_REQ: begin
                    if (mem_done || tmo_hit) begin
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                    if (mem_done && !mismatch) begin
                        state <= S_GAP;
                        if (last) begin
                            phase <= phase_t'(phase + 2'd1);
                            fin   <= phase == PH_BR;
                        end
                    end else if (mem_done || tmo_hit) begin
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        fail     <= 1'b1;
                        err_code <= !mem_done ? ERR_TMO : (phase == PH_BR) ? ERR_BYTE : ERR_WORD;
                        err_addr <= mem_addr;
                        err_exp  <= exp_word;
                        err_got  <= mem_done ? mem_rdata : 16'h0000;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                S_PASS: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    pass  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bist.sv
// tb_ram_bist: directed checks of ram_bist against a 256-word byte-lane SRAM responder
// (done one cycle after a request, then one idle recovery cycle) with injectable faults.
module tb_ram_bist;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, pass, fail;
    logic [1:0]  err_code;
    logic [17:0] err_addr, mem_addr;
    logic [15:0] err_exp, err_got, mem_wdata, mem_rdata;
    logic        mem_rd, mem_wr, mem_wr_inhibit, mem_byte_op, mem_done;

    logic [15:0] mem [0:255];
    logic        r_done = 1'b0;
    logic        rec = 1'b0;
    logic [15:0] r_rdata = '0;
    logic [7:0]  idx;
    int          fault = 0;
    logic        spike = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [92:0] all_outs;

    always #5 clk = ~clk;

    ram_bist #(.ADDR_LO(18'h00000), .ADDR_HI(18'h0000E)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .busy           (busy),
        .pass           (pass),
        .fail           (fail),
        .err_code       (err_code),
        .err_addr       (err_addr),
        .err_exp        (err_exp),
        .err_got        (err_got),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_wr_inhibit (mem_wr_inhibit),
        .mem_byte_op    (mem_byte_op),
        .mem_done       (mem_done)
    );

    assign idx       = mem_addr[8:1];
    assign mem_rdata = r_rdata;
    assign mem_done  = r_done | (spike & busy & ~mem_rd & ~mem_wr);
    assign all_outs  = {busy, pass, fail, err_code, err_addr, err_exp, err_got,
                        mem_addr, mem_wdata, mem_rd, mem_wr, mem_wr_inhibit, mem_byte_op};

    // Faults: 1 = bit 3 of word 0x06 reads back 0, 2 = upper-lane byte write at 0x04 stores 0,
    // 3 = no acknowledge for address 0x08.
    always @(posedge clk) begin
        if (reset) begin
            r_done <= 1'b0;
            rec    <= 1'b0;
        end else if (r_done) begin
            r_done <= 1'b0;
            rec    <= 1'b1;
        end else if (rec) begin
            rec <= 1'b0;
        end else if ((mem_rd || mem_wr) && !(fault == 3 && mem_addr == 18'h08)) begin
            r_done  <= 1'b1;
            r_rdata <= (fault == 1 && idx == 8'd3) ? (mem[idx] & 16'hFFF7) : mem[idx];
            if (mem_wr) begin
                if (!mem_byte_op)
                    mem[idx] <= mem_wdata;
                else if (mem_addr[0])
                    mem[idx][15:8] <= (fault == 2 && idx == 8'd2) ? 8'h00 : mem_wdata[7:0];
                else
                    mem[idx][7:0] <= mem_wdata[7:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pulses start and follows the run until busy drops (or the bound expires).
    task automatic run(input int bound, input bit hammer, output int bcyc, output int reqs,
                       output logic [3:0] first_flags, output int t08, output int tf);
        bit prev = 1'b0;
        bcyc = 0;
        reqs = 0;
        t08 = -1;
        tf = -1;
        first_flags = 4'hF;
        start = 1'b1;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            start = hammer && busy;
            if (i == 0) first_flags = {pass, fail, err_code};
            if (busy) bcyc++;
            if ((mem_rd || mem_wr) && !prev) reqs++;
            prev = mem_rd || mem_wr;
            if (t08 < 0 && mem_wr && mem_addr == 18'h08) t08 = i;
            if (tf < 0 && fail) tf = i;
            if (!busy) break;
        end
        start = 1'b0;
        chk("run_ends", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int bc, rq, t08, tf;
        logic [3:0] ff;
        idle(3);
        chk("reset_outs", all_outs, '0);
        reset = 1'b0;
        idle(2);

        // clean run
        run(400, 1'b0, bc, rq, ff, t08, tf);
        chk("t1_pass", pass, 1'b1);
        chk("t1_fail", fail, 1'b0);
        chk("t1_code", err_code, 2'd0);
        chk("t1_busy_cycles", bc, 98);
        chk("t1_reqs", rq, 32);

        fault = 1;
        idle(3);
        run(400, 1'b0, bc, rq, ff, t08, tf);
        chk("t2_fail", fail, 1'b1);
        chk("t2_pass", pass, 1'b0);
        chk("t2_code", err_code, 2'd1);
        chk("t2_addr", err_addr, 18'h06);
        chk("t2_exp", err_exp, 16'h5A3F);
        chk("t2_got", err_got, 16'h5A37);

        fault = 2;
        idle(3);
        run(400, 1'b0, bc, rq, ff, t08, tf);
        chk("t3_clear_on_start", ff, 4'h0);
        chk("t3_fail", fail, 1'b1);
        chk("t3_code", err_code, 2'd2);
        chk("t3_addr", err_addr, 18'h04);
        chk("t3_exp", err_exp, 16'hA73E);
        chk("t3_got", err_got, 16'h003E);

        fault = 3;
        idle(3);
        run(400, 1'b0, bc, rq, ff, t08, tf);
        chk("t4_fail", fail, 1'b1);
        chk("t4_code", err_code, 2'd3);
        chk("t4_addr", err_addr, 18'h08);
        chk("t4_got", err_got, 16'h0000);
        chk("t4_req_low", {mem_rd, mem_wr}, 2'b00);
        chk("t4_wait_cycles", tf - t08, 255);

        fault = 0;
        idle(3);
        start = 1'b1;
        idle(1);
        start = 1'b0;
        for (int i = 0; i < 100 && !mem_rd; i++) idle(1);
        chk("t5_in_phase2", mem_rd, 1'b1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t5_reset_outs", all_outs, '0);
        idle(2);
        run(400, 1'b0, bc, rq, ff, t08, tf);
        chk("t5_pass", pass, 1'b1);
        chk("t5_busy_cycles", bc, 98);

        spike = 1'b1;
        idle(3);
        run(400, 1'b1, bc, rq, ff, t08, tf);
        spike = 1'b0;
        chk("t6_pass", pass, 1'b1);
        chk("t6_code", err_code, 2'd0);
        chk("t6_reqs", rq, 32);
        chk("t6_busy_cycles", bc, 98);
        idle(2);
        chk("t6_no_restart", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
